// File: rtl/nandy_bist_pkg.sv
// Shared types and tables for the NAND gate built-in self-test.
package nandy_bist_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  localparam int unsigned VecIdxW = 2;
  localparam int unsigned NumVecs = 4;

  // {a,b} sweep order 00,10,11,01: each step flips exactly one input.
  localparam logic [NumVecs-1:0][1:0] VecTable = {2'b01, 2'b11, 2'b10, 2'b00};

  // Expected NAND output per table entry (bit i belongs to VecTable[i]).
  localparam logic [NumVecs-1:0] ExpQTable = 4'b1011;

endpackage

// File: rtl/nand_gate_bist_if.sv
// Stimulus/result bundle between the BIST controller and its host.
interface nand_gate_bist_if #(
  parameter int unsigned ERR_W = 8
);

  logic             start;
  logic             q;
  logic             a;
  logic             b;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic             first_fail_valid;
  logic [1:0]       first_fail_vec;

  // BIST controller side.
  modport master (
    input  start, q,
    output a, b, busy, done, pass, err_count, first_fail_valid, first_fail_vec
  );

  // Host / gate-under-test side.
  modport slave (
    output start, q,
    input  a, b, busy, done, pass, err_count, first_fail_valid, first_fail_vec
  );

endinterface

// File: rtl/nand_gate_bist_settle_timer.sv
// Loadable down-counter; expire_o marks the edge at which q is sampled.
module nand_gate_bist_settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic expire_o
);

  localparam int unsigned CntW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CntW-1:0] Reload = CntW'(SETTLE_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Reload on request, otherwise count down and rest at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = Reload;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/nand_gate_bist.sv
// Drives a NAND gate through its truth table and checks q after a settle time.
module nand_gate_bist
  import nandy_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 5,
  parameter int unsigned PASSES        = 1,
  parameter int unsigned ERR_W         = 8
) (
  input logic               clk,
  input logic               rst,
  nand_gate_bist_if.master  bus
);

  localparam int unsigned PassW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [PassW-1:0] LastPass = PassW'(PASSES - 1);
  localparam logic [ERR_W-1:0] ErrMax = '1;

  state_e               state_q;
  logic [VecIdxW-1:0]   vec_idx_q;
  logic [PassW-1:0]     pass_idx_q;
  logic                 a_q, b_q, busy_q, done_q, pass_q;
  logic [ERR_W-1:0]     err_q;
  logic                 ffv_q;
  logic [1:0]           ffvec_q;

  logic                 expire, sample, mismatch, last_vec, timer_load;
  logic [VecIdxW-1:0]   vec_idx_nxt;
  logic [ERR_W-1:0]     err_d;

  nand_gate_bist_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (timer_load),
    .expire_o (expire)
  );

  // Sample decision, saturating error increment and timer reload.
  always_comb begin
    sample      = (state_q == StRun) && expire;
    mismatch    = sample && (bus.q != ExpQTable[vec_idx_q]);
    err_d       = (mismatch && (err_q != ErrMax)) ? err_q + 1'b1 : err_q;
    last_vec    = (vec_idx_q == VecIdxW'(NumVecs - 1)) && (pass_idx_q == LastPass);
    vec_idx_nxt = vec_idx_q + 1'b1;
    timer_load  = ((state_q == StIdle) && bus.start) || (sample && !last_vec);
  end

  // Run-control FSM with all result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      vec_idx_q  <= '0;
      pass_idx_q <= '0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      ffv_q      <= 1'b0;
      ffvec_q    <= 2'b00;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            ffv_q        <= 1'b0;
            ffvec_q      <= 2'b00;
            busy_q       <= 1'b1;
            {a_q, b_q}   <= VecTable[0];
            vec_idx_q    <= '0;
            pass_idx_q   <= '0;
            state_q      <= StRun;
          end
        end
        StRun: begin
          if (sample) begin
            err_q <= err_d;
            if (mismatch && !ffv_q) begin
              ffv_q   <= 1'b1;
              ffvec_q <= {a_q, b_q};
            end
            if (last_vec) begin
              a_q     <= 1'b0;
              b_q     <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_d == '0);
              state_q <= StIdle;
            end else begin
              vec_idx_q  <= vec_idx_nxt;
              {a_q, b_q} <= VecTable[vec_idx_nxt];
              if (vec_idx_q == VecIdxW'(NumVecs - 1)) begin
                pass_idx_q <= pass_idx_q + 1'b1;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.a                = a_q;
  assign bus.b                = b_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.pass             = pass_q;
  assign bus.err_count        = err_q;
  assign bus.first_fail_valid = ffv_q;
  assign bus.first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_nand_gate_bist.sv
// Randomized bench: four BIST configurations against a timeline model of the sweep.
module tb_nand_gate_bist;

  localparam int NI = 4;
  localparam int MDly  = 0;  // ideal NAND delayed by cur_dly cycles (0 = combinational)
  localparam int MOne  = 1;  // q stuck at 1
  localparam int MZero = 2;  // q stuck at 0
  localparam int MNoise = 3; // q random every cycle

  function automatic int s_of(input int i);
    return (i == 2) ? 7 : 5;
  endfunction
  function automatic int p_of(input int i);
    return (i == 1 || i == 3) ? 2 : 1;
  endfunction
  function automatic int e_of(input int i);
    return (i == 3) ? 2 : 8;
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic q_v = 1'b1;
  logic start_v [NI];

  wire       a_w     [NI];
  wire       b_w     [NI];
  wire       busy_w  [NI];
  wire       done_w  [NI];
  wire       pass_w  [NI];
  wire       ffv_w   [NI];
  wire [1:0] ffvec_w [NI];
  wire [7:0] err_w   [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned EW = e_of(g);
    nand_gate_bist_if #(.ERR_W(EW)) u_if ();
    assign u_if.start = start_v[g];
    assign u_if.q     = q_v;
    assign a_w[g]     = u_if.a;
    assign b_w[g]     = u_if.b;
    assign busy_w[g]  = u_if.busy;
    assign done_w[g]  = u_if.done;
    assign pass_w[g]  = u_if.pass;
    assign ffv_w[g]   = u_if.first_fail_valid;
    assign ffvec_w[g] = u_if.first_fail_vec;
    assign err_w[g]   = 8'(u_if.err_count);
    nand_gate_bist #(
      .SETTLE_CYCLES(s_of(g)),
      .PASSES       (p_of(g)),
      .ERR_W        (EW)
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.master)
    );
  end

  int n_chk  = 0;
  int n_pass = 0;

  int          act = 0;
  int          cur_mode = MDly;
  int          cur_dly = 0;
  int          rel = -1;
  logic [15:0] hist = '1;
  logic        qlog [64];
  logic [1:0]  vec_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One cycle: advance to the falling edge and drive q for the active instance.
  task automatic step();
    @(negedge clk);
    hist = {hist[14:0], ~(a_w[act] & b_w[act])};
    case (cur_mode)
      MDly:    q_v = hist[cur_dly];
      MOne:    q_v = 1'b1;
      MZero:   q_v = 1'b0;
      default: q_v = 1'($urandom);
    endcase
    if (rel >= 0 && rel < 64) qlog[rel] = q_v;
    if (rel >= 0) rel++;
  endtask

  task automatic check_reset(input int g, input string tag);
    check($sformatf("%s%0d_ab", tag, g), {a_w[g], b_w[g]}, 2'b00);
    check($sformatf("%s%0d_busy", tag, g), busy_w[g], 1'b0);
    check($sformatf("%s%0d_done", tag, g), done_w[g], 1'b0);
    check($sformatf("%s%0d_pass", tag, g), pass_w[g], 1'b0);
    check($sformatf("%s%0d_err", tag, g), err_w[g], 8'd0);
    check($sformatf("%s%0d_ffv", tag, g), ffv_w[g], 1'b0);
    check($sformatf("%s%0d_ffvec", tag, g), ffvec_w[g], 2'b00);
  endtask

  // Full run on instance g; inj>0 pulses start mid-run, abort_at>=0 asserts rst mid-run.
  task automatic do_run(input int g, input int mode, input int dly, input int inj,
                        input int abort_at);
    int s, p, lim, nvec, mism, first, sat;
    logic [1:0] in_v;
    logic qs;
    s = s_of(g); p = p_of(g); nvec = 4 * p; lim = nvec * s;
    sat = (1 << e_of(g)) - 1;
    act = g; cur_mode = mode; cur_dly = dly; rel = -1;
    repeat (10) step();
    start_v[g] = 1'b1;
    rel = 0;
    for (int k = 1; k <= lim; k++) begin
      step();
      check($sformatf("run%0d_ab_c%0d", g, k - 1), {a_w[g], b_w[g]}, vec_tab[((k - 1) / s) % 4]);
      check($sformatf("run%0d_busy_c%0d", g, k - 1), busy_w[g], 1'b1);
      check($sformatf("run%0d_done_c%0d", g, k - 1), done_w[g], 1'b0);
      if (k == 1) begin
        check($sformatf("run%0d_err_clr", g), err_w[g], 8'd0);
        check($sformatf("run%0d_ffv_clr", g), ffv_w[g], 1'b0);
        check($sformatf("run%0d_pass_clr", g), pass_w[g], 1'b0);
      end
      start_v[g] = (inj > 0) && (k - 1 == inj);
      if (k - 1 == abort_at) begin
        rst = 1'b1;
        step();
        check_reset(g, "abort");
        rst = 1'b0;
        start_v[g] = 1'b0;
        for (int m = 0; m < lim + 2; m++) begin
          step();
          check($sformatf("abort%0d_nodone_%0d", g, m), {done_w[g], busy_w[g]}, 2'b00);
        end
        return;
      end
    end
    step();
    start_v[g] = 1'b0;
    // Reference: find the q seen at each sample edge and score it against NAND.
    mism = 0; first = -1;
    for (int v = 0; v < nvec; v++) begin
      int smp, j;
      smp = (v + 1) * s - 1;
      if (mode == MDly) begin
        j = smp - dly;
        in_v = (j < 0) ? 2'b00 : vec_tab[(j / s) % 4];
        qs = ~(in_v[1] & in_v[0]);
      end else if (mode == MOne) qs = 1'b1;
      else if (mode == MZero) qs = 1'b0;
      else qs = qlog[smp];
      in_v = vec_tab[v % 4];
      if (qs != ~(in_v[1] & in_v[0])) begin
        mism++;
        if (first < 0) first = v % 4;
      end
    end
    if (mism > sat) mism = sat;
    for (int h = 0; h < 3; h++) begin
      check($sformatf("end%0d_done_h%0d", g, h), done_w[g], 1'b1);
      check($sformatf("end%0d_err_h%0d", g, h), err_w[g], 8'(mism));
      if (h > 0) step();
    end
    check($sformatf("end%0d_busy", g), busy_w[g], 1'b0);
    check($sformatf("end%0d_ab", g), {a_w[g], b_w[g]}, 2'b00);
    check($sformatf("end%0d_pass", g), pass_w[g], (mism == 0));
    check($sformatf("end%0d_ffv", g), ffv_w[g], (first >= 0));
    check($sformatf("end%0d_ffvec", g), ffvec_w[g], (first >= 0) ? vec_tab[first] : 2'b00);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) start_v[i] = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    for (int i = 0; i < NI; i++) check_reset(i, "rst");
    rst = 1'b0;

    do_run(0, MDly, 0, -1, -1);   // ideal gate
    do_run(0, MOne, 0, -1, -1);   // stuck-1 fails only on 11
    do_run(1, MZero, 0, -1, -1);  // stuck-0, two passes -> 6 errors
    do_run(0, MDly, 6, -1, -1);   // slow gate, short settle
    do_run(2, MDly, 6, -1, -1);   // slow gate, long enough settle
    do_run(0, MDly, 0, 3, -1);    // start while busy ignored
    do_run(0, MDly, 0, -1, 7);    // rst at cycle 8 of run
    do_run(3, MZero, 0, -1, -1);  // saturates at 3
    do_run(3, MDly, 0, -1, -1);   // next start clears errors

    for (int r = 0; r < 16; r++) begin
      int g, inj;
      g = int'($urandom_range(NI - 1, 0));
      inj = ($urandom_range(1, 0) == 1) ? int'($urandom_range(4 * p_of(g) * s_of(g) - 1, 1)) : -1;
      do_run(g, int'($urandom_range(3, 0)), int'($urandom_range(8, 0)), inj, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
